// File: rtl/comar_logic_vec.sv
// comar_logic_vec: WIDTH-lane, 2-share, first-order COMAR masked AND/OR gadget.
// Two en-stallable register stages; share 1 of the result is the caller's common_out.
module comar_logic_vec #(
  parameter int WIDTH    = 8,
  parameter int OPT      = 0,
  parameter int PIPELINE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic               op,
  input  logic [WIDTH-1:0]   a_s0,
  input  logic [WIDTH-1:0]   a_s1,
  input  logic [WIDTH-1:0]   b_s0,
  input  logic [WIDTH-1:0]   b_s1,
  input  logic [6*WIDTH-1:0] r,
  input  logic [WIDTH-1:0]   common_out,
  output logic [WIDTH-1:0]   c_s0,
  output logic [WIDTH-1:0]   c_s1,
  output logic               out_valid
);

  if (PIPELINE != 1) begin : g_pipeline_check
    $error("comar_logic_vec: only PIPELINE=1 is supported");
  end

  logic [WIDTH-1:0] r_a, r_b, r_00, r_01, r_10, r_11;
  logic [WIDTH-1:0] ref_a, ref_b, op_v;

  always_comb begin
    r_a  = '0;
    r_b  = '0;
    r_00 = '0;
    r_01 = '0;
    r_10 = '0;
    r_11 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r_a[i]  = r[6*i];
      r_b[i]  = r[6*i+1];
      r_00[i] = r[6*i+2];
      r_01[i] = r[6*i+3];
      r_10[i] = r[6*i+4];
      r_11[i] = r[6*i+5];
    end
  end

  // Without share-1 refresh registers the share-0 refresh could not cancel, so it is dropped too.
  assign ref_a = (OPT == 0) ? r_a : '0;
  assign ref_b = (OPT == 0) ? r_b : '0;
  assign op_v  = {WIDTH{op}};

  logic [WIDTH-1:0] x0_q, x0_d, y0_q, y0_d, x1, y1;
  logic             op1_q, op1_d, v1_q, v1_d;
  logic [WIDTH-1:0] p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
  logic             op2_q, op2_d, v2_q, v2_d;

  if (OPT == 0) begin : g_s1_refresh
    logic [WIDTH-1:0] x1_q, x1_d, y1_q, y1_d;

    always_comb begin
      x1_d = en ? (a_s1 ^ r_a) : x1_q;
      y1_d = en ? (b_s1 ^ r_b) : y1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x1_q <= '0;
        y1_q <= '0;
      end else begin
        x1_q <= x1_d;
        y1_q <= y1_d;
      end
    end

    assign x1 = x1_q;
    assign y1 = y1_q;
  end else begin : g_s1_direct
    assign x1 = a_s1;
    assign y1 = b_s1;
  end

  always_comb begin
    x0_d  = en ? (a_s0 ^ ref_a ^ op_v) : x0_q;
    y0_d  = en ? (b_s0 ^ ref_b ^ op_v) : y0_q;
    op1_d = en ? op       : op1_q;
    v1_d  = en ? in_valid : v1_q;
    p00_d = en ? ((x0_q & y0_q) ^ r_00) : p00_q;
    p01_d = en ? ((x0_q & y1)   ^ r_01) : p01_q;
    p10_d = en ? ((x1   & y0_q) ^ r_10) : p10_q;
    p11_d = en ? ((x1   & y1)   ^ r_11) : p11_q;
    op2_d = en ? op1_q : op2_q;
    v2_d  = en ? v1_q  : v2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q  <= '0;
      y0_q  <= '0;
      op1_q <= 1'b0;
      v1_q  <= 1'b0;
      p00_q <= '0;
      p01_q <= '0;
      p10_q <= '0;
      p11_q <= '0;
      op2_q <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      x0_q  <= x0_d;
      y0_q  <= y0_d;
      op1_q <= op1_d;
      v1_q  <= v1_d;
      p00_q <= p00_d;
      p01_q <= p01_d;
      p10_q <= p10_d;
      p11_q <= p11_d;
      op2_q <= op2_d;
      v2_q  <= v2_d;
    end
  end

  // Share 0 compresses only registered, already-masked products.
  assign c_s0      = p00_q ^ p01_q ^ p10_q ^ p11_q ^ {WIDTH{op2_q}};
  assign c_s1      = common_out;
  assign out_valid = v2_q;

endmodule
